iomem_timer: RTL and testbench

- Memory-mapped down-counting timer on the picosoc iomem bus. Shares the bus with the GPIO block and decodes its own address window.
- Produces a level interrupt that is wired to soc irq_5.
- Gives firmware (Zephyr system tick) a periodic or one-shot event source with a programmable prescaler.

---
 rtl/iomem_timer.sv | 144 ++++++++++++++
 tb/tb_iomem_timer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iomem_timer.sv
// iomem_timer: down-counting timer with prescaler and level irq on the picosoc iomem bus.
// Define IOMEM_TIMER_PWM_EN to add the DUTY register (0x14) and drive pwm_out.
module iomem_timer #(
  parameter logic [7:0]  BASE_ADDR_HI = 8'h04,
  parameter int unsigned PRESCALE_W   = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq,
  output logic        pwm_out
);
  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_PRESCALE = 8'h04;
  localparam logic [7:0] OFF_RELOAD   = 8'h08;
  localparam logic [7:0] OFF_COUNT    = 8'h0C;
  localparam logic [7:0] OFF_STATUS   = 8'h10;

  function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [3:0] strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[b*8 +: 8] = strb[b] ? wd[b*8 +: 8] : old[b*8 +: 8];
    return res;
  endfunction

  logic                  en, auto_rl, irq_en, pending;
  logic [PRESCALE_W-1:0] prescale, pcnt;
  logic [31:0]           reload, count;
  logic                  hit, wr, tick, expire, en_nxt;
  logic                  wr_ctrl, wr_prescale, wr_reload, wr_count, wr_status;
  logic [7:0]            off;
  logic [31:0]           ctrl_val, prescale_val, rd_val;
  logic [31:0]           ctrl_wr, prescale_wr, reload_wr, count_wr;

  assign off          = iomem_addr[7:0];
  assign hit          = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE_ADDR_HI);
  assign wr           = hit && (iomem_wstrb != 4'd0);
  assign wr_ctrl      = wr && (off == OFF_CTRL);
  assign wr_prescale  = wr && (off == OFF_PRESCALE);
  assign wr_reload    = wr && (off == OFF_RELOAD);
  assign wr_count     = wr && (off == OFF_COUNT);
  assign wr_status    = wr && (off == OFF_STATUS);

  assign ctrl_val     = {29'd0, irq_en, auto_rl, en};
  assign prescale_val = 32'(prescale);
  assign ctrl_wr      = byte_merge(ctrl_val, iomem_wdata, iomem_wstrb);
  assign prescale_wr  = byte_merge(prescale_val, iomem_wdata, iomem_wstrb);
  assign reload_wr    = byte_merge(reload, iomem_wdata, iomem_wstrb);
  assign count_wr     = byte_merge(count, iomem_wdata, iomem_wstrb);

  assign tick   = en && (pcnt == prescale);
  assign expire = tick && (count == 32'd0);

`ifdef IOMEM_TIMER_PWM_EN
  localparam logic [7:0] OFF_DUTY = 8'h14;
  logic [31:0] duty;
`endif

  always_comb begin
    rd_val = 32'd0;
    case (off)
      OFF_CTRL:     rd_val = ctrl_val;
      OFF_PRESCALE: rd_val = prescale_val;
      OFF_RELOAD:   rd_val = reload;
      OFF_COUNT:    rd_val = count;
      OFF_STATUS:   rd_val = {31'd0, pending};
`ifdef IOMEM_TIMER_PWM_EN
      OFF_DUTY:     rd_val = duty;
`endif
      default:      rd_val = 32'd0;
    endcase
  end

  // A bus CTRL write overrides the one-shot hardware clear on the same edge.
  always_comb begin
    en_nxt = en;
    if (expire && !auto_rl) en_nxt = 1'b0;
    if (wr_ctrl)            en_nxt = ctrl_wr[0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= 32'd0;
      irq         <= 1'b0;
      en          <= 1'b0;
      auto_rl     <= 1'b0;
      irq_en      <= 1'b0;
      prescale    <= '0;
      pcnt        <= '0;
      reload      <= 32'd0;
      count       <= 32'd0;
      pending     <= 1'b0;
    end else begin
      iomem_ready <= hit;
      if (hit) iomem_rdata <= rd_val;
      en <= en_nxt;
      if (wr_ctrl) begin
        auto_rl <= ctrl_wr[1];
        irq_en  <= ctrl_wr[2];
      end
      if (wr_prescale) prescale <= prescale_wr[PRESCALE_W-1:0];
      if (wr_reload)   reload   <= reload_wr;
      // Prescaler only runs across edges where the timer stays enabled.
      pcnt <= (en && en_nxt && !tick) ? pcnt + 1'b1 : '0;
      if (wr_count)
        count <= count_wr;
      else if (tick && !expire)
        count <= count - 32'd1;
      else if (expire && auto_rl)
        count <= reload;
      // Expiry set beats a same-edge software clear.
      if (expire)
        pending <= 1'b1;
      else if (wr_status && iomem_wstrb[0] && iomem_wdata[0])
        pending <= 1'b0;
      irq <= pending & irq_en;
    end
  end

`ifdef IOMEM_TIMER_PWM_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      duty    <= 32'd0;
      pwm_out <= 1'b0;
    end else begin
      if (wr && (off == OFF_DUTY)) duty <= byte_merge(duty, iomem_wdata, iomem_wstrb);
      pwm_out <= en && (count < duty);
    end
  end
`else
  assign pwm_out = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{iomem_addr[23:8], ctrl_wr[31:3], prescale_wr[31:PRESCALE_W]};

endmodule

// File: tb/tb_iomem_timer.sv
// tb_iomem_timer: directed timing scenarios plus random bus traffic scored against a cycle model.
`timescale 1ns/1ps
module tb_iomem_timer;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = 4'd0;
  logic [31:0] iomem_addr = 32'd0;
  logic [31:0] iomem_wdata = 32'd0;
  logic [31:0] iomem_rdata;
  logic        irq, pwm_out;

  int tests = 0, fails = 0;
  int cyc = 0, last_acc = 0;

`ifdef IOMEM_TIMER_PWM_EN
  localparam bit HAS_PWM = 1'b1;
`else
  localparam bit HAS_PWM = 1'b0;
`endif
  localparam logic [31:0] B = 32'h0400_0000;

  iomem_timer dut (
    .clk(clk), .resetn(resetn), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata), .irq(irq), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model: register file + timer rules, one step per clock
  typedef struct packed {
    logic        en, auto_rl, ien, pend, irq, ready, pwm;
    logic [15:0] psc, pre;
    logic [31:0] reload, count, duty, rdata;
  } mstate_t;
  mstate_t m;

  function automatic logic [31:0] bytes_in(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = s[b] ? wd[b*8 +: 8] : old[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] reg_value(input mstate_t s, input logic [7:0] o);
    case (o)
      8'h00:   return {29'd0, s.ien, s.auto_rl, s.en};
      8'h04:   return {16'd0, s.pre};
      8'h08:   return s.reload;
      8'h0C:   return s.count;
      8'h10:   return {31'd0, s.pend};
      8'h14:   return HAS_PWM ? s.duty : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic mstate_t step(input mstate_t s, input logic v, input logic [3:0] st,
                                   input logic [31:0] a, input logic [31:0] wd);
    mstate_t     n = s;
    logic        sel = v && !s.ready && (a[31:24] == 8'h04);
    logic        wr = sel && (st != 4'd0);
    logic [7:0]  o = a[7:0];
    logic        fire = s.en && (s.psc == s.pre);
    logic        done = fire && (s.count == 32'd0);
    logic [31:0] c = bytes_in({29'd0, s.ien, s.auto_rl, s.en}, wd, st);
    logic [31:0] p = bytes_in({16'd0, s.pre}, wd, st);
    n.ready = sel;
    n.irq   = s.pend && s.ien;
    n.pwm   = HAS_PWM && s.en && (s.count < s.duty);
    if (sel) n.rdata = reg_value(s, o);
    if (done) begin
      n.pend = 1'b1;
      if (s.auto_rl) n.count = s.reload; else n.en = 1'b0;
    end else if (fire) n.count = s.count - 32'd1;
    if (wr) begin
      case (o)
        8'h00: begin n.en = c[0]; n.auto_rl = c[1]; n.ien = c[2]; end
        8'h04: n.pre = p[15:0];
        8'h08: n.reload = bytes_in(s.reload, wd, st);
        8'h0C: n.count = bytes_in(s.count, wd, st);
        8'h10: if (st[0] && wd[0] && !done) n.pend = 1'b0;
        8'h14: if (HAS_PWM) n.duty = bytes_in(s.duty, wd, st);
        default: ;
      endcase
    end
    n.psc = (s.en && n.en && !fire) ? s.psc + 16'd1 : 16'd0;
    return n;
  endfunction

  always @(posedge clk or negedge resetn)
    if (!resetn) m <= '0;
    else         m <= step(m, iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata);

  // ---------------- bus helpers (called just after a clock edge)
  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd);
    bit got = 1'b0;
    iomem_addr = a; iomem_wdata = d; iomem_wstrb = s; iomem_valid = 1'b1;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      got = iomem_ready;
    end
    rd = iomem_rdata; last_acc = cyc;
    iomem_valid = 1'b0; iomem_wstrb = 4'd0;
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL bus_ready addr=%h: no ready within 4 clks, required one", a);
    end
  endtask

  task automatic wr32(input logic [7:0] o, input logic [31:0] d);
    logic [31:0] x;
    bus(B | 32'(o), d, 4'hF, x);
  endtask

  task automatic rd32(input logic [7:0] o, output logic [31:0] d);
    bus(B | 32'(o), 32'd0, 4'h0, d);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_irq(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (irq) begin at = cyc; break; end
    end
  endtask

  // ---------------- scenarios
  task automatic test_reset();
    logic [31:0] d;
    logic [7:0]  offs [5] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10};
    resetn = 1'b0;
    idle(3);
    tests++;
    if ({iomem_ready, irq, pwm_out, iomem_rdata} !== 35'd0) begin
      fails++; $display("FAIL reset_hold outs=%h required 0", {iomem_ready, irq, pwm_out, iomem_rdata});
    end
    resetn = 1'b1;
    idle(2);
    tests++;
    if ({iomem_ready, irq, pwm_out, iomem_rdata} !== 35'd0) begin
      fails++; $display("FAIL reset_release outs=%h required 0", {iomem_ready, irq, pwm_out, iomem_rdata});
    end
    foreach (offs[i]) begin
      rd32(offs[i], d);
      tests++;
      if (d !== 32'd0) begin fails++; $display("FAIL reset_read off=%h got %h required 0", offs[i], d); end
    end
    idle(1);
    tests++;
    if (iomem_ready !== 1'b0) begin fails++; $display("FAIL ready_pulse got %b required 0", iomem_ready); end
    // reset landing right after a write edge wipes the write and the ack
    iomem_addr = B | 32'h08; iomem_wdata = 32'h1234; iomem_wstrb = 4'hF; iomem_valid = 1'b1;
    idle(1);
    resetn = 1'b0; #1;
    tests++;
    if ({iomem_ready, iomem_rdata} !== 33'd0) begin
      fails++; $display("FAIL reset_async ready/rdata=%h required 0", {iomem_ready, iomem_rdata});
    end
    iomem_valid = 1'b0; iomem_wstrb = 4'd0;
    idle(1);
    resetn = 1'b1;
    idle(1);
    rd32(8'h08, d);
    tests++;
    if (d !== 32'd0) begin fails++; $display("FAIL reset_midwrite reload=%h required 0", d); end
  endtask

  task automatic test_strobes();
    logic [31:0] d;
    bit seen = 1'b0;
    bus(B | 32'h08, 32'hAABB_CCDD, 4'b0101, d);
    rd32(8'h08, d);
    tests++;
    if (d !== 32'h00BB_00DD) begin fails++; $display("FAIL strobe_reload got %h required 00bb00dd", d); end
    iomem_addr = 32'h0500_0008; iomem_wdata = 32'hFFFF_FFFF; iomem_wstrb = 4'hF; iomem_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; if (iomem_ready) seen = 1'b1; end
    iomem_valid = 1'b0; iomem_wstrb = 4'd0;
    tests++;
    if (seen) begin fails++; $display("FAIL foreign_ready got 1 required 0"); end
    rd32(8'h08, d);
    tests++;
    if (d !== 32'h00BB_00DD) begin fails++; $display("FAIL foreign_write reload=%h required 00bb00dd", d); end
    wr32(8'h18, 32'h5A5A_5A5A);
    rd32(8'h18, d);
    tests++;
    if (d !== 32'd0) begin fails++; $display("FAIL unmapped_read got %h required 0", d); end
  endtask

  task automatic test_periodic();
    int e0, at;
    wr32(8'h04, 32'd3);
    wr32(8'h08, 32'd4);
    wr32(8'h0C, 32'd4);
    wr32(8'h00, 32'h7);
    e0 = last_acc;
    for (int k = 1; k <= 3; k++) begin
      wait_irq(60, at);
      tests++;
      if (at - e0 !== 20*k + 1) begin
        fails++; $display("FAIL periodic_irq%0d at +%0d clks required +%0d", k, at - e0, 20*k + 1);
      end
      wr32(8'h10, 32'h1);
      tests++;
      if (irq !== 1'b1) begin fails++; $display("FAIL irq_hold_on_clear got %b required 1", irq); end
      idle(1);
      tests++;
      if (irq !== 1'b0) begin fails++; $display("FAIL irq_drop got %b required 0", irq); end
    end
    wr32(8'h00, 32'h0);
    wr32(8'h10, 32'h1);
  endtask

  task automatic test_oneshot();
    int e0, at;
    logic [31:0] d;
    bit seen = 1'b0;
    wr32(8'h04, 32'd0);
    wr32(8'h0C, 32'd2);
    wr32(8'h00, 32'h5);
    e0 = last_acc;
    wait_irq(20, at);
    tests++;
    if (at - e0 !== 4) begin fails++; $display("FAIL oneshot_irq at +%0d clks required +4", at - e0); end
    rd32(8'h00, d);
    tests++;
    if (d !== 32'h4) begin fails++; $display("FAIL oneshot_ctrl got %h required 4", d); end
    rd32(8'h0C, d);
    tests++;
    if (d !== 32'd0) begin fails++; $display("FAIL oneshot_count got %h required 0", d); end
    wr32(8'h10, 32'h1);
    for (int i = 0; i < 30; i++) begin @(posedge clk); #1; if (i > 0 && irq) seen = 1'b1; end
    tests++;
    if (seen) begin fails++; $display("FAIL oneshot_rearm irq seen, required none"); end
    rd32(8'h10, d);
    tests++;
    if (d !== 32'd0) begin fails++; $display("FAIL oneshot_status got %h required 0", d); end
  endtask

  task automatic test_collision();
    int e0;
    logic [31:0] d;
    // PRESCALE=0, COUNT=3: expiry lands on the 4th edge after the CTRL write
    wr32(8'h08, 32'd5);
    wr32(8'h0C, 32'd3);
    wr32(8'h00, 32'h3);
    e0 = last_acc;
    idle(3);
    wr32(8'h10, 32'h1);
    tests++;
    if (last_acc - e0 !== 4) begin fails++; $display("FAIL clr_align at +%0d required +4", last_acc - e0); end
    rd32(8'h10, d);
    tests++;
    if (d !== 32'h1) begin fails++; $display("FAIL clr_vs_expiry status=%h required 1", d); end
    wr32(8'h00, 32'h0);
    wr32(8'h10, 32'h1);
    // PRESCALE=1: ticks on even edges after the CTRL write, so the COUNT write lands on a tick
    wr32(8'h04, 32'd1);
    wr32(8'h0C, 32'd20);
    wr32(8'h00, 32'h3);
    e0 = last_acc;
    wr32(8'h0C, 32'd9);
    tests++;
    if (last_acc - e0 !== 2) begin fails++; $display("FAIL cnt_align at +%0d required +2", last_acc - e0); end
    rd32(8'h0C, d);
    tests++;
    if (d !== 32'd9) begin fails++; $display("FAIL cnt_vs_tick count=%0d required 9", d); end
    wr32(8'h00, 32'h0);
    wr32(8'h10, 32'h1);
  endtask

  task automatic test_pwm();
    logic [31:0] d;
    int highs = 0;
    bit bad = 1'b0;
`ifdef IOMEM_TIMER_PWM_EN
    wr32(8'h04, 32'd0);
    wr32(8'h08, 32'd9);
    wr32(8'h14, 32'd3);
    wr32(8'h0C, 32'd9);
    wr32(8'h00, 32'h3);
    rd32(8'h14, d);
    tests++;
    if (d !== 32'd3) begin fails++; $display("FAIL duty_read got %h required 3", d); end
    idle(5);
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (pwm_out) highs++; end
    tests++;
    if (highs !== 12) begin fails++; $display("FAIL pwm_duty3 high %0d of 40 required 12", highs); end
    wr32(8'h14, 32'd0);
    idle(2);
    for (int i = 0; i < 20; i++) begin @(posedge clk); #1; if (pwm_out) bad = 1'b1; end
    tests++;
    if (bad) begin fails++; $display("FAIL pwm_duty0 saw high required constant 0"); end
    wr32(8'h14, 32'd20);
    idle(2);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin @(posedge clk); #1; if (!pwm_out) bad = 1'b1; end
    tests++;
    if (bad) begin fails++; $display("FAIL pwm_duty_big saw low required constant 1"); end
    wr32(8'h00, 32'h0);
    idle(2);
    tests++;
    if (pwm_out !== 1'b0) begin fails++; $display("FAIL pwm_disabled got %b required 0", pwm_out); end
`else
    wr32(8'h14, 32'hFFFF_FFFF);
    rd32(8'h14, d);
    tests++;
    if (d !== 32'd0) begin fails++; $display("FAIL duty_absent read %h required 0", d); end
    wr32(8'h04, 32'd0);
    wr32(8'h08, 32'd9);
    wr32(8'h00, 32'h3);
    for (int i = 0; i < 30; i++) begin @(posedge clk); #1; if (pwm_out !== 1'b0) bad = 1'b1; end
    tests++;
    if (bad) begin fails++; $display("FAIL pwm_absent saw non-zero required constant 0"); end
    highs = 0;
    wr32(8'h00, 32'h0);
`endif
    wr32(8'h10, 32'h1);
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [7:0]  offs [8] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h40};
    logic [7:0]  o;
    bit          seen;
    for (int n = 0; n < 250; n++) begin
      o = offs[$urandom_range(0, 7)];
      case ($urandom_range(0, 8))
        0, 1, 2: rd32(o, d);
        3: bus(B | 32'h0C, 32'($urandom_range(0, 12)), 4'($urandom_range(1, 15)), d);
        4: bus(B | 32'h08, 32'($urandom_range(0, 8)), 4'hF, d);
        5: bus(B | 32'h04, 32'($urandom_range(0, 3)), 4'hF, d);
        6: bus(B | 32'h10, 32'($urandom_range(0, 1)), 4'hF, d);
        7: bus(B | 32'h00, 32'($urandom_range(0, 7)), 4'($urandom_range(1, 15)), d);
        default: bus(B | 32'h14, 32'($urandom_range(0, 12)), 4'hF, d);
      endcase
      tests++;
      if (d !== m.rdata) begin fails++; $display("FAIL rand_rdata n=%0d got %h required %h", n, d, m.rdata); end
      tests++;
      if (irq !== m.irq || pwm_out !== m.pwm) begin
        fails++; $display("FAIL rand_irq_pwm n=%0d got %b%b required %b%b", n, irq, pwm_out, m.irq, m.pwm);
      end
      if ($urandom_range(0, 9) == 0) begin
        seen = 1'b0;
        iomem_addr = 32'h0300_0000 | 32'(o); iomem_wdata = $urandom; iomem_wstrb = 4'hF; iomem_valid = 1'b1;
        repeat (2) begin @(posedge clk); #1; if (iomem_ready) seen = 1'b1; end
        iomem_valid = 1'b0; iomem_wstrb = 4'd0;
        tests++;
        if (seen) begin fails++; $display("FAIL rand_foreign n=%0d got ready required none", n); end
      end
      idle($urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_strobes();
    test_periodic();
    test_oneshot();
    test_collision();
    test_pwm();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
